// File: rtl/fir_sig_gen.sv
// fir_sig_gen: test-signal source for a FIR filter input. Emits signed samples
// (triangle tone from a phase accumulator, optionally plus LFSR noise) with a
// one-cycle en_o strobe every div+1 cycles, for len samples or continuously.
// Optional feature macro: FIR_SIG_GEN_NOISE_EN (adds the LFSR noise source and
// output saturation; when undefined the output is the pure triangle).
module fir_sig_gen #(
  parameter int          SIG_W     = 8,
  parameter int          ACC_W     = 16,
  parameter int          DIV_W     = 8,
  parameter int          LEN_W     = 16,
  parameter int          NOISE_W   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [DIV_W-1:0]        div_i,
  input  logic [ACC_W-1:0]        step_i,
  input  logic [LEN_W-1:0]        len_i,
  output logic signed [SIG_W-1:0] noisy_sig_o,
  output logic                    en_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [SIG_W-1:0] TONE_OFS = SIG_W'(2 ** (SIG_W - 2));

  // Elaboration-time parameter sanity check
  if (SIG_W < 4 || ACC_W < SIG_W || NOISE_W > SIG_W || NOISE_W < 1 ||
      LFSR_SEED == 16'h0000) begin : g_bad_cfg
    $error("fir_sig_gen: illegal parameter combination");
  end

  state_t                  state_q;
  logic [DIV_W-1:0]        div_q;
  logic [ACC_W-1:0]        step_q;
  logic [LEN_W-1:0]        len_q;
  logic [ACC_W-1:0]        acc_q;
  logic [DIV_W-1:0]        cnt_q;
  logic [LEN_W-1:0]        scnt_q;
  logic signed [SIG_W-1:0] sig_q;
  logic                    en_q;
  logic                    done_q;
  logic                    busy_q;

  logic [SIG_W-1:0]        p;
  logic [SIG_W-2:0]        t;
  logic [SIG_W-1:0]        tone;
  logic signed [SIG_W-1:0] sample_d;

`ifdef FIR_SIG_GEN_NOISE_EN
  localparam logic signed [SIG_W:0] SAT_MAX = (SIG_W+1)'(2 ** (SIG_W - 1) - 1);
  localparam logic signed [SIG_W:0] SAT_MIN = (SIG_W+1)'(-(2 ** (SIG_W - 1)));

  logic [15:0]             lfsr_q;
  logic [15:0]             lfsr_d;
  logic signed [SIG_W:0]   noise;
  logic signed [SIG_W:0]   sum;
`endif

  // Sample generation from the current (pre-advance) accumulator and LFSR
  always_comb begin
    p    = acc_q[ACC_W-1 -: SIG_W];
    t    = p[SIG_W-1] ? ~p[SIG_W-2:0] : p[SIG_W-2:0];
    tone = {1'b0, t} - TONE_OFS;
`ifdef FIR_SIG_GEN_NOISE_EN
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    noise  = {{(SIG_W + 1 - NOISE_W){lfsr_q[NOISE_W-1]}}, lfsr_q[NOISE_W-1:0]};
    sum    = $signed({tone[SIG_W-1], tone}) + noise;
    if (sum > SAT_MAX)      sample_d = SAT_MAX[SIG_W-1:0];
    else if (sum < SAT_MIN) sample_d = SAT_MIN[SIG_W-1:0];
    else                    sample_d = sum[SIG_W-1:0];
`else
    sample_d = tone;
`endif
  end

  // Run-control FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      scnt_q  <= '0;
      sig_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FIR_SIG_GEN_NOISE_EN
      lfsr_q  <= LFSR_SEED;
`endif
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            div_q   <= div_i;
            step_q  <= step_i;
            len_q   <= len_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            scnt_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stop_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == div_q) begin
            cnt_q <= '0;
            en_q  <= 1'b1;
            sig_q <= sample_d;
            acc_q <= acc_q + step_q;
`ifdef FIR_SIG_GEN_NOISE_EN
            lfsr_q <= lfsr_d;
`endif
            // Continuous mode (len 0) leaves the sample count frozen.
            if (len_q != '0) begin
              if (scnt_q == len_q - 1'b1) state_q <= DONE;
              else                        scnt_q  <= scnt_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // DONE coincides with the final en_o cycle; the registered done_o
          // therefore lands on the following cycle, as busy_o drops.
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign noisy_sig_o = sig_q;
  assign en_o        = en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_fir_sig_gen.sv
// tb_fir_sig_gen: directed bench for fir_sig_gen with hand-computed samples.
// Expected sample tables follow FIR_SIG_GEN_NOISE_EN so the bench matches
// whichever build of the generator it is compiled with.
module tb_fir_sig_gen;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [7:0]        div;
  logic [15:0]       step;
  logic [15:0]       len;
  logic signed [7:0] sig;
  logic              en;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef FIR_SIG_GEN_NOISE_EN
  // Noise sequence after reseed: +1, 0, -8, -4, -2 (ACE1,5670,AB38,559C,2ACE)
  localparam int T1E [3] = '{-63, -64, -72};
  localparam int T2E [3] = '{-63, -56, -56};
  localparam int T3E [5] = '{-63, 0, 55, -5, -66};
  localparam int T4E [2] = '{-63, -56};
`else
  localparam int T1E [3] = '{-64, -64, -64};
  localparam int T2E [3] = '{-64, -56, -48};
  localparam int T3E [5] = '{-64, 0, 63, -1, -64};
  localparam int T4E [2] = '{-64, -56};
`endif

  fir_sig_gen dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .stop_i     (stop),
    .div_i      (div),
    .step_i     (step),
    .len_i      (len),
    .noisy_sig_o(sig),
    .en_o       (en),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] d, input logic [15:0] s,
                           input logic [15:0] l);
    div   = d;
    step  = s;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    div   = '0;
    step  = '0;
    len   = '0;
    tick();
    tick();
    check("rst_sig",  $signed(sig), 0);
    check("rst_en",   en,   0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // T1: div=0 step=0 len=3, three back-to-back strobes
    start_run(8'd0, 16'h0000, 16'd3);
    check("t1_busy", busy, 1);
    check("t1_en0",  en,   0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_en",  en, 1);
      check("t1_sig", $signed(sig), T1E[i]);
      check("t1_nodone", done, 0);
    end
    tick();
    check("t1_en_off", en,   0);
    check("t1_done",   done, 1);
    tick();
    check("t1_done_off", done, 0);
    check("t1_idle",     busy, 0);
    check("t1_hold",     $signed(sig), T1E[2]);

    // T2: div=3 step=0x0800 len=3, strobe every 4th edge
    do_reset();
    start_run(8'd3, 16'h0800, 16'd3);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        check("t2_gap", en, 0);
      end
      tick();
      check("t2_en",  en, 1);
      check("t2_sig", $signed(sig), T2E[i]);
    end
    tick();
    check("t2_done", done, 1);
    tick();
    check("t2_idle", busy, 0);

    // T3: div=0 step=0x4000 len=5, triangle fold and accumulator wrap
    do_reset();
    start_run(8'd0, 16'h4000, 16'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_en",  en, 1);
      check("t3_sig", $signed(sig), T3E[i]);
    end
    tick();
    check("t3_done", done, 1);
    check("t3_en_off", en, 0);

    // T4: continuous run, ignored restart, stop on a strobe edge
    do_reset();
    start_run(8'd1, 16'h0800, 16'd0);
    tick();
    check("t4_gap0", en, 0);
    tick();
    check("t4_en0",  en, 1);
    check("t4_sig0", $signed(sig), T4E[0]);
    div   = 8'd0;
    len   = 16'd2;
    step  = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_gap1", en,   0);
    check("t4_busy", busy, 1);
    tick();
    check("t4_en1",  en, 1);
    check("t4_sig1", $signed(sig), T4E[1]);
    tick();
    check("t4_gap2", en, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_stop_en",   en,   0);
    check("t4_stop_busy", busy, 0);
    check("t4_stop_done", done, 0);
    check("t4_stop_hold", $signed(sig), T4E[1]);
    tick();
    check("t4_after_done", done, 0);
    check("t4_after_en",   en,   0);

    // T5: reset mid-run, then restart reproduces the first sample
    do_reset();
    start_run(8'd0, 16'h0000, 16'd3);
    tick();
    check("t5_sig_pre", $signed(sig), T1E[0]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_sig",  $signed(sig), 0);
    check("t5_rst_en",   en,   0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    start_run(8'd0, 16'h0000, 16'd3);
    tick();
    check("t5_sig0", $signed(sig), T1E[0]);
    tick();
    check("t5_sig1", $signed(sig), T1E[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
